// File: rtl/four_greater_than.sv
// Registered MSB-first magnitude comparator (unsigned or two's-complement)
// with a saturating count of greater-than results.
module four_greater_than #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic             cnt_clr,
   output logic             y,
   output logic             eq,
   output logic             lt,
   output logic             out_valid,
   output logic [CNT_W-1:0] gt_count
);

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   logic [WIDTH-1:0] a_m;
   logic [WIDTH-1:0] b_m;

   assign a_m = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
   assign b_m = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};

   // Ripple from the MSB: the first differing bit decides the ordering.
   logic [WIDTH:0] gt_chain;
   logic [WIDTH:0] eq_chain;

   assign gt_chain[WIDTH] = 1'b0;
   assign eq_chain[WIDTH] = 1'b1;

   genvar gi;
   generate
      for (gi = WIDTH - 1; gi >= 0; gi = gi - 1) begin : g_cmp
         assign gt_chain[gi] = gt_chain[gi+1] |
                               (eq_chain[gi+1] & a_m[gi] & ~b_m[gi]);
         assign eq_chain[gi] = eq_chain[gi+1] & ~(a_m[gi] ^ b_m[gi]);
      end
   endgenerate

   logic gt_next;
   logic eq_next;
   logic lt_next;

   assign gt_next = gt_chain[0];
   assign eq_next = eq_chain[0];
   assign lt_next = ~gt_chain[0] & ~eq_chain[0];

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y         <= 1'b0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         out_valid <= 1'b0;
         gt_count  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y  <= gt_next;
            eq <= eq_next;
            lt <= lt_next;
         end
         if (cnt_clr) begin
            gt_count <= '0;
         end else if (in_valid && gt_next && (gt_count != CNT_MAX)) begin
            gt_count <= gt_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_four_greater_than.sv
// Randomized and directed checks of four_greater_than against an
// integer-arithmetic reference model.
module tb_four_greater_than;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       signed_mode;
   logic       cnt_clr;
   logic       y;
   logic       eq;
   logic       lt;
   logic       out_valid;
   logic [7:0] gt_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_y, m_eq, m_lt, m_ov;
   int m_cnt;

   four_greater_than #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
      .signed_mode(signed_mode), .cnt_clr(cnt_clr), .y(y), .eq(eq), .lt(lt),
      .out_valid(out_valid), .gt_count(gt_count)
   );

   always #5 clk = ~clk;

   function automatic int to_int(input logic [3:0] v, input bit sm);
      int r;
      r = int'(v);
      if (sm && r >= 8) r = r - 16;
      return r;
   endfunction

   task automatic model_reset();
      m_y = 0; m_eq = 0; m_lt = 0; m_ov = 0; m_cnt = 0;
   endtask

   // Drive one cycle of inputs, let an edge pass, then advance the model.
   task automatic cycle(input logic [3:0] va, input logic [3:0] vb,
                        input bit sm, input bit v, input bit clr);
      int ia, ib;
      a = va; b = vb; signed_mode = sm; in_valid = v; cnt_clr = clr;
      @(posedge clk);
      #1;
      ia = to_int(va, sm);
      ib = to_int(vb, sm);
      m_ov = v;
      if (v) begin
         m_y = (ia > ib); m_eq = (ia == ib); m_lt = (ia < ib);
      end
      if (clr) m_cnt = 0;
      else if (v && ia > ib && m_cnt < 255) m_cnt = m_cnt + 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      signed_mode = 1'b0; cnt_clr = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({y, eq, lt, out_valid, gt_count} !== 12'h0) begin
         errors++;
         $display("FAIL reset_state got y=%b eq=%b lt=%b ov=%b cnt=%0d want all 0",
                  y, eq, lt, out_valid, gt_count);
      end
      in_valid = 1'b1; a = 4'hF;
      @(posedge clk); #1;
      checks++;
      if ({y, out_valid, gt_count} !== 10'h0) begin
         errors++;
         $display("FAIL reset_hold got y=%b ov=%b cnt=%0d want 0 0 0", y, out_valid, gt_count);
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_plan(input bit sm, input logic [3:0] exp_y_seq,
                            input int exp_cnt, input string name);
      logic [3:0] pa [4] = '{4'b0110, 4'b0010, 4'b0100, 4'b1000};
      logic [3:0] pb [4] = '{4'b0000, 4'b1000, 4'b1101, 4'b0001};
      cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(pa[i], pb[i], sm, 1'b1, 1'b0);
         checks++;
         if (y !== exp_y_seq[3-i] || lt !== ~exp_y_seq[3-i] || eq !== 1'b0 ||
             {y, eq, lt} !== {m_y, m_eq, m_lt}) begin
            errors++;
            $display("FAIL %s_flags[%0d] got y=%b eq=%b lt=%b want y=%b eq=0 lt=%b",
                     name, i, y, eq, lt, exp_y_seq[3-i], ~exp_y_seq[3-i]);
         end
         $display("%s sample %0d a=%b b=%b y=%b eq=%b lt=%b cnt=%0d",
                  name, i, pa[i], pb[i], y, eq, lt, gt_count);
      end
      checks++;
      if (int'(gt_count) !== exp_cnt) begin
         errors++;
         $display("FAIL %s_count got %0d want %0d", name, gt_count, exp_cnt);
      end
   endtask

   task automatic test_equal_hold();
      int saved;
      cycle(4'b1010, 4'b1010, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({y, eq, lt, out_valid} !== 4'b0101) begin
         errors++;
         $display("FAIL equal got y=%b eq=%b lt=%b ov=%b want 0 1 0 1", y, eq, lt, out_valid);
      end
      saved = m_cnt;
      cycle(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({y, eq, lt, out_valid} !== 4'b0100 || int'(gt_count) !== saved) begin
         errors++;
         $display("FAIL hold got y=%b eq=%b lt=%b ov=%b cnt=%0d want 0 1 0 0 cnt=%0d",
                  y, eq, lt, out_valid, gt_count, saved);
      end
      $display("test_equal_hold done");
   endtask

   task automatic test_saturation();
      cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) cycle(4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0);
      checks++;
      if (gt_count !== 8'd255) begin
         errors++;
         $display("FAIL saturate got %0d want 255", gt_count);
      end
      $display("saturation count=%0d", gt_count);
      cycle(4'b0111, 4'b0000, 1'b0, 1'b1, 1'b1);
      checks++;
      if (gt_count !== 8'd0 || y !== 1'b1) begin
         errors++;
         $display("FAIL clear_override got cnt=%0d y=%b want 0 1", gt_count, y);
      end
      $display("clear count=%0d", gt_count);
   endtask

   task automatic test_async_reset();
      cycle(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
      checks++;
      if (y !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_y got %b want 1", y);
      end
      in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({y, eq, lt, out_valid, gt_count} !== 12'h0) begin
         errors++;
         $display("FAIL async_reset got y=%b eq=%b lt=%b ov=%b cnt=%0d want all 0",
                  y, eq, lt, out_valid, gt_count);
      end
      #2 rst_n = 1'b1;
      cycle(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
      checks++;
      if (y !== 1'b1 || out_valid !== 1'b1 || gt_count !== 8'd1) begin
         errors++;
         $display("FAIL post_reset got y=%b ov=%b cnt=%0d want 1 1 1", y, out_valid, gt_count);
      end
      $display("test_async_reset done");
   endtask

   task automatic test_boundary();
      cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
      checks++;
      if (y !== 1'b1) begin
         errors++;
         $display("FAIL bound_unsigned_max got y=%b want 1", y);
      end
      cycle(4'b0111, 4'b1000, 1'b1, 1'b1, 1'b0);
      checks++;
      if (y !== 1'b1) begin
         errors++;
         $display("FAIL bound_signed_pos got y=%b want 1", y);
      end
      cycle(4'b1000, 4'b0111, 1'b1, 1'b1, 1'b0);
      checks++;
      if (lt !== 1'b1 || y !== 1'b0) begin
         errors++;
         $display("FAIL bound_signed_neg got lt=%b y=%b want 1 0", lt, y);
      end
      $display("test_boundary done");
   endtask

   task automatic test_random();
      logic [3:0] ra, rb;
      bit rs, rv, rc;
      for (int i = 0; i < 400; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
         rs = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 4) != 0);
         rc = ($urandom_range(0, 40) == 0);
         cycle(ra, rb, rs, rv, rc);
         checks++;
         if ({y, eq, lt, out_valid, gt_count} !==
             {m_y, m_eq, m_lt, m_ov, 8'(m_cnt)}) begin
            errors++;
            $display("FAIL random[%0d] a=%b b=%b s=%b v=%b c=%b got %b%b%b ov=%b cnt=%0d want %b%b%b ov=%b cnt=%0d",
                     i, ra, rb, rs, rv, rc, y, eq, lt, out_valid, gt_count,
                     m_y, m_eq, m_lt, m_ov, m_cnt);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_plan(1'b0, 4'b1001, 2, "unsigned");
      test_plan(1'b1, 4'b1110, 3, "signed");
      test_equal_hold();
      test_saturation();
      test_async_reset();
      test_boundary();
      test_random();
      in_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
